// File: rtl/mdc_pkg.sv
// Shared types and constants for the MDC feeder: FSM states, raw mode codes, Hamming geometry.
// No logic or latency of its own; the position helper is only evaluated during loop unrolling.
package mdc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [4:0] MODE_2X2 = 5'b00100;
   localparam logic [4:0] MODE_3X3 = 5'b00110;
   localparam logic [4:0] MODE_4X4 = 5'b10110;

   localparam int DAT_DW  = 11;
   localparam int DAT_CW  = 15;
   localparam int MODE_DW = 5;
   localparam int MODE_CW = 9;
   localparam int N_ELEM  = 16;
   localparam int RES_W   = 207;

   // Data bit feeding codeword position pos (1-based, MSB = position 1).
   function automatic int hm_data_idx(input int dw, input int pos);
      int np;
      np = 0;
      for (int p = 1; p <= pos; p = p * 2) np++;
      return dw - pos + np;
   endfunction

endpackage

// File: rtl/mdc_feeder_hamming_enc.sv
// Even-parity Hamming encoder: codeword MSB is position 1, parity at powers of two.
// Purely combinational (zero latency); carries no flow control.
module hamming_enc
   import mdc_pkg::*;
#(
   parameter int DW = 11,
   parameter int CW = 15
) (
   input  logic [DW-1:0] data,
   output logic [CW-1:0] code
);

   logic [CW-1:0] raw;
   logic [CW-1:0] par;

   always_comb begin
      raw = '0;
      for (int pos = 1; pos <= CW; pos++) begin
         if ((pos & (pos - 1)) != 0) raw[CW-pos] = data[hm_data_idx(DW, pos)];
      end
   end

   always_comb begin
      par = '0;
      for (int p = 1; p <= CW; p = p * 2) begin
         for (int pos = 1; pos <= CW; pos++) begin
            if (((pos & p) != 0) && (pos != p)) par[CW-p] = par[CW-p] ^ raw[CW-pos];
         end
      end
   end

   assign code = raw | par;

endmodule

// File: rtl/mdc_feeder.sv
// Streams one captured 16-element job into the MDC as Hamming codewords, then waits for its result or a timeout.
// Latency: 16 SEND cycles after accept, result 1 cycle after out_valid; req_ready held low until the job finishes. Option: MDC_FEEDER_ERRINJ_EN.
module mdc_feeder
   import mdc_pkg::*;
#(
   parameter int MAT_W   = 11,
   parameter int TMO_CYC = 1000
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef MDC_FEEDER_ERRINJ_EN
   input  logic                errinj_en,
   input  logic [3:0]          errinj_pos,
`endif
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [4:0]          req_mode,
   input  logic [16*MAT_W-1:0] req_mat,
   output logic                in_valid,
   output logic [8:0]          in_mode,
   output logic [14:0]         in_data,
   input  logic                out_valid,
   input  logic [206:0]        out_data,
   output logic                res_valid,
   output logic [206:0]        res_data,
   output logic                res_tmo
);

   localparam int TW = $clog2(TMO_CYC + 1);

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic [TW-1:0]         tmo_cnt;
   logic [4:0]            mode_q;
   logic [16*MAT_W-1:0]   mat_q;
   logic                  accept, cap, tmo_hit;
   logic [MAT_W-1:0]      elem;
   logic [DAT_CW-1:0]     data_cw, inj_mask;
   logic [MODE_CW-1:0]    mode_cw;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign cap       = (state == WAIT) && out_valid;
   // Capture takes priority over a timeout landing in the same cycle.
   assign tmo_hit   = (state == WAIT) && !out_valid && (tmo_cnt == TW'(TMO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SEND;
         SEND:    if (cnt == 4'(N_ELEM - 1)) state_nxt = WAIT;
         WAIT:    if (cap || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         tmo_cnt   <= '0;
         mode_q    <= '0;
         mat_q     <= '0;
         res_valid <= 1'b0;
         res_tmo   <= 1'b0;
         res_data  <= '0;
      end else begin
         cnt       <= (state == SEND) ? cnt + 4'd1 : 4'd0;
         tmo_cnt   <= (state == WAIT && !cap && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
         res_valid <= cap || tmo_hit;
         res_tmo   <= tmo_hit;
         if (accept) begin
            mode_q <= req_mode;
            mat_q  <= req_mat;
         end
         if (cap) res_data <= out_data;
      end
   end

`ifdef MDC_FEEDER_ERRINJ_EN
   logic       inj_en_q;
   logic [3:0] inj_pos_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_en_q  <= 1'b0;
         inj_pos_q <= '0;
      end else if (accept) begin
         inj_en_q  <= errinj_en;
         inj_pos_q <= errinj_pos;
      end
   end

   // Position p maps to codeword bit CW-p since position 1 is the MSB.
   assign inj_mask = (inj_en_q && inj_pos_q != 4'd0)
                   ? (DAT_CW'(1) << (DAT_CW - int'(inj_pos_q))) : '0;
`else
   assign inj_mask = '0;
`endif

   assign elem = mat_q[cnt*MAT_W +: MAT_W];

   hamming_enc #(.DW(DAT_DW), .CW(DAT_CW)) u_enc_dat (
      .data (DAT_DW'(elem)),
      .code (data_cw)
   );

   hamming_enc #(.DW(MODE_DW), .CW(MODE_CW)) u_enc_mode (
      .data (mode_q),
      .code (mode_cw)
   );

   assign in_valid = (state == SEND);
   assign in_mode  = (state == SEND && cnt == 4'd0) ? mode_cw : '0;
   assign in_data  = (state == SEND) ? (data_cw ^ inj_mask) : '0;

endmodule

// File: tb/tb_mdc_feeder.sv
// Directed bench for mdc_feeder: vector table of encoded modes/elements plus timeout, capture and reset sequences.
module tb_mdc_feeder;
   import mdc_pkg::*;

   localparam int MAT_W = 11;
   localparam int TMO   = 8;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic [4:0]          req_mode = '0;
   logic [16*MAT_W-1:0] req_mat = '0;
   logic                in_valid;
   logic [8:0]          in_mode;
   logic [14:0]         in_data;
   logic                out_valid = 1'b0;
   logic [206:0]        out_data = '0;
   logic                res_valid;
   logic [206:0]        res_data;
   logic                res_tmo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mdc_feeder #(.MAT_W(MAT_W), .TMO_CYC(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MDC_FEEDER_ERRINJ_EN
      .errinj_en (1'b0),
      .errinj_pos(4'd0),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_mat   (req_mat),
      .in_valid  (in_valid),
      .in_mode   (in_mode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_tmo   (res_tmo)
   );

   typedef struct {
      logic [4:0]  mode;
      logic [10:0] val;
      int          slot;
      logic [8:0]  exp_mode;
      logic [14:0] exp_data;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [206:0] act, input logic [206:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic start_job(input logic [4:0] mode, input logic [10:0] val, input int slot);
      logic [16*MAT_W-1:0] m;
      int w;
      m = '0;
      m[slot*MAT_W +: MAT_W] = val;
      @(negedge clk);
      req_valid = 1'b1;
      req_mode  = mode;
      req_mat   = m;
      w = 0;
      while (!req_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("accept_ready", req_ready, 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_mode  = 5'h1F;
      req_mat   = '1;
   endtask

   task automatic check_send(input logic [8:0] em, input int slot, input logic [14:0] ed,
                             input bit ov_in_send, input int abort_j);
      for (int j = 1; j <= 16; j++) begin
         @(negedge clk);
         chk("send_in_valid", in_valid, 1);
         chk("send_in_mode", in_mode, (j == 1) ? em : 9'h0);
         chk("send_in_data", in_data, (j - 1 == slot) ? ed : 15'h0);
         chk("send_req_ready", req_ready, 0);
         if (ov_in_send) out_valid = (j != 16);
         if (j == abort_j) return;
      end
   endtask

   task automatic finish_cap(input int d, input logic [206:0] dat);
      for (int i = 1; i <= d; i++) begin
         @(negedge clk);
         chk("wait_res_valid", res_valid, 0);
         chk("wait_in_valid", in_valid, 0);
         chk("wait_in_data", in_data, 0);
         chk("wait_req_ready", req_ready, 0);
         if (i == d) begin
            out_valid = 1'b1;
            out_data  = dat;
         end
      end
      @(negedge clk);
      out_valid = 1'b0;
      out_data  = {7'h55, 200'hDEAD_BEEF};
      chk("cap_res_valid", res_valid, 1);
      chk("cap_res_tmo", res_tmo, 0);
      chk("cap_res_data", res_data, dat);
      chk("cap_req_ready", req_ready, 1);
      @(negedge clk);
      chk("cap_pulse_end", res_valid, 0);
      chk("cap_data_hold", res_data, dat);
   endtask

   task automatic finish_tmo(input logic [206:0] old);
      for (int i = 1; i <= TMO; i++) begin
         @(negedge clk);
         chk("tmo_wait_res_valid", res_valid, 0);
         chk("tmo_wait_req_ready", req_ready, 0);
      end
      @(negedge clk);
      chk("tmo_res_valid", res_valid, 1);
      chk("tmo_res_tmo", res_tmo, 1);
      chk("tmo_res_data", res_data, old);
      chk("tmo_req_ready", req_ready, 1);
      @(negedge clk);
      chk("tmo_pulse_end", res_valid, 0);
      chk("tmo_flag_end", res_tmo, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [206:0] last_res;
      bit           seen;

      vecs[0] = '{MODE_4X4, 11'h001,  0, 9'h0CC, 15'h6881};
      vecs[1] = '{MODE_2X2, 11'h400,  5, 9'h0A8, 15'h7000};
      vecs[2] = '{MODE_3X3, 11'h7FF, 15, 9'h10C, 15'h7FFF};
      vecs[3] = '{MODE_4X4, 11'h002,  9, 9'h0CC, 15'h2882};
      vecs[4] = '{MODE_2X2, 11'h080,  3, 9'h0A8, 15'h6900};
      vecs[5] = '{MODE_3X3, 11'h555, 12, 9'h10C, 15'h5A55};

      #1;
      chk("rst_in_valid", in_valid, 0);
      chk("rst_in_mode", in_mode, 0);
      chk("rst_in_data", in_data, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_tmo", res_tmo, 0);
      chk("rst_res_data", res_data, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_req_ready", req_ready, 1);

      last_res = '0;
      for (int i = 0; i < 6; i++) begin
         start_job(vecs[i].mode, vecs[i].val, vecs[i].slot);
         check_send(vecs[i].exp_mode, vecs[i].slot, vecs[i].exp_data, 1'b0, -1);
         if (i == 0) last_res = 207'h1234;
         else        last_res = {7'(i), 200'(i * 1000 + 7)};
         finish_cap((i == 0) ? 5 : i + 1, last_res);
      end

      // out_valid held high through IDLE and SEND must not produce a capture.
      @(negedge clk);
      out_valid = 1'b1;
      out_data  = {7'h7F, 200'hBAD};
      repeat (2) @(negedge clk);
      chk("idle_ov_ignored", res_valid, 0);
      start_job(MODE_4X4, 11'h001, 7);
      check_send(9'h0CC, 7, 15'h6881, 1'b1, -1);
      finish_tmo(last_res);

      start_job(MODE_3X3, 11'h400, 2);
      check_send(9'h10C, 2, 15'h7000, 1'b0, -1);
      last_res = {7'h2A, 200'hABCDE};
      finish_cap(TMO, last_res);

      // Reset in the middle of SEND, right at element 7.
      start_job(MODE_4X4, 11'h7FF, 10);
      check_send(9'h0CC, 10, 15'h7FFF, 1'b0, 8);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_valid", in_valid, 0);
      chk("mid_rst_in_data", in_data, 0);
      chk("mid_rst_in_mode", in_mode, 0);
      chk("mid_rst_res_data", res_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_req_ready", req_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < TMO + 20; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      chk("mid_rst_no_result", seen, 0);

      start_job(MODE_2X2, 11'h001, 0);
      check_send(9'h0A8, 0, 15'h6881, 1'b0, -1);
      finish_cap(3, 207'h5A5A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
